// File: rtl/mem_march_initiator.sv
// March-style self-test initiator for a request/response RAM: writes seed^addr patterns, reads back, compares.
// Optional INV_PASS_EN adds a second write+read pass using the inverted pattern.
module mem_march_initiator #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              response,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              timeout
);
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] seed_q;
  logic [WCW-1:0]    wait_cnt;
  logic [ADDR_W:0]   err_q;
  logic [ADDR_W-1:0] ferr_q;
  logic              to_q;
  logic [DATA_W-1:0] pat;
  logic              last_addr, start_ok, req, expire, mism;

`ifdef INV_PASS_EN
  logic inv_q;
  assign pat = inv_q ? ~(seed_q ^ {(DATA_W/ADDR_W){addr_q}}) : (seed_q ^ {(DATA_W/ADDR_W){addr_q}});
`else
  assign pat = seed_q ^ {(DATA_W/ADDR_W){addr_q}};
`endif

  assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign req       = (state == WR_REQ) || (state == RD_REQ);
  // Last tolerated wait cycle: the request has then been held TIMEOUT cycles.
  assign expire    = req && !response && (wait_cnt == WCW'(TIMEOUT - 1));
  assign mism      = (state == RD_REQ) && response && (rdata != pat);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = WR_REQ;
      WR_REQ:  if (response) state_nx = WR_GAP;
               else if (expire) state_nx = DONE;
      WR_GAP:  state_nx = last_addr ? RD_REQ : WR_REQ;
      RD_REQ:  if (response) state_nx = RD_GAP;
               else if (expire) state_nx = DONE;
      RD_GAP: begin
        if (last_addr) begin
`ifdef INV_PASS_EN
          state_nx = inv_q ? DONE : WR_REQ;
`else
          state_nx = DONE;
`endif
        end else begin
          state_nx = RD_REQ;
        end
      end
      DONE:    if (start) state_nx = WR_REQ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      seed_q   <= '0;
      wait_cnt <= '0;
      err_q    <= '0;
      ferr_q   <= '0;
      to_q     <= 1'b0;
`ifdef INV_PASS_EN
      inv_q    <= 1'b0;
`endif
    end else if (start_ok) begin
      addr_q   <= '0;
      seed_q   <= seed;
      wait_cnt <= '0;
      err_q    <= '0;
      ferr_q   <= '0;
      to_q     <= 1'b0;
`ifdef INV_PASS_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      case (state)
        WR_REQ, RD_REQ: begin
          if (response) wait_cnt <= '0;
          else if (expire) to_q <= 1'b1;
          else wait_cnt <= wait_cnt + WCW'(1);
          if (mism) begin
            if (err_q != (ADDR_W+1)'(DEPTH)) err_q <= err_q + (ADDR_W+1)'(1);
            if (err_q == '0) ferr_q <= addr_q;
          end
        end
        WR_GAP: begin
          wait_cnt <= '0;
          addr_q   <= last_addr ? '0 : addr_q + ADDR_W'(1);
        end
        RD_GAP: begin
          wait_cnt <= '0;
          if (!last_addr) addr_q <= addr_q + ADDR_W'(1);
`ifdef INV_PASS_EN
          else if (!inv_q) begin
            inv_q  <= 1'b1;
            addr_q <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign wr             = (state == WR_REQ);
  assign rd             = (state == RD_REQ);
  assign addr           = addr_q;
  assign wdata          = wr ? pat : '0;
  assign busy           = (state != IDLE) && (state != DONE);
  assign done           = (state == DONE);
  assign pass           = done && (err_q == '0) && !to_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;
  assign timeout        = to_q;
endmodule

// File: tb/tb_mem_march_initiator.sv
// Randomized bench for mem_march_initiator: behavioural RAM responder with delays/corruption plus result model.
module tb_mem_march_initiator;
  localparam int D = 16;
`ifdef INV_PASS_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  localparam int LAT = INV ? 8*D : 4*D;

  logic        clk = 1'b0;
  logic        reset, start, response;
  logic [31:0] seed, rdata, wdata;
  logic        wr, rd, busy, done, pass, timeout;
  logic [3:0]  addr, first_err_addr;
  logic [4:0]  err_cnt;

  always #5 clk = ~clk;

  mem_march_initiator dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .response(response),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .timeout(timeout)
  );

  logic [31:0] mem [D];
  logic [31:0] corrupt [D];
  int          max_dly = 0;
  bit          hang_en = 1'b0;
  int          viol = 0;
  int          wr2_cyc = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  function automatic logic [31:0] mexp(input logic [31:0] s, input int a);
    return s ^ (32'(a) * 32'h1111_1111);
  endfunction

  // RAM responder and protocol monitor; runs on the falling edge so the DUT sees stable inputs.
  initial begin
    bit          prev_req = 1'b0, prev_wr = 1'b0;
    logic [3:0]  prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    int          wait_left = -1;
    response = 1'b0;
    rdata    = '0;
    forever begin
      @(negedge clk);
      if (wr && rd) viol++;
      if (prev_req && response && (wr || rd)) viol++;
      if (prev_req && !response && (wr || rd) &&
          (wr != prev_wr || addr != prev_addr || (wr && wdata != prev_wdata))) viol++;
      if (hang_en && wr && addr == 4'd2) wr2_cyc++;
      prev_req = wr || rd; prev_wr = wr; prev_addr = addr; prev_wdata = wdata;
      if (!(wr || rd)) begin
        response  = 1'b0;
        wait_left = -1;
      end else begin
        if (wait_left < 0) wait_left = int'($urandom_range(max_dly, 0));
        if (hang_en && wr && addr == 4'd2) begin
          response = 1'b0;
        end else if (wait_left == 0) begin
          response = 1'b1;
          if (wr) mem[addr] = wdata;
          else    rdata = mem[addr] ^ corrupt[addr];
          wait_left = -1;
        end else begin
          response = 1'b0;
          wait_left--;
        end
      end
    end
  end

  task automatic run(input logic [31:0] s, input int pulse_at, output int cyc, output logic [12:0] post);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    post  = {busy, done, pass, timeout, err_cnt, first_err_addr};
    while (!done && cyc < 5000) begin
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("run.bound", 64'(cyc < 5000), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] s);
    int n = 0, first = 0, bad = 0;
    bit found = 1'b0;
    for (int a = 0; a < D; a++)
      if (corrupt[a] != 0) begin
        n++;
        if (!found) begin first = a; found = 1'b1; end
      end
    if (INV) n = n * 2;
    if (n > D) n = D;
    for (int a = 0; a < D; a++)
      if (mem[a] !== (mexp(s, a) ^ (INV ? 32'hFFFF_FFFF : 32'h0))) bad++;
    chk({tag, ".done"},  64'(done), 64'd1);
    chk({tag, ".err"},   64'(err_cnt), 64'(n));
    chk({tag, ".first"}, 64'(first_err_addr), 64'(first));
    chk({tag, ".pass"},  64'(pass), 64'(n == 0));
    chk({tag, ".to"},    64'(timeout), 64'd0);
    chk({tag, ".mem"},   64'(bad), 64'd0);
  endtask

  task automatic clr_corrupt();
    for (int a = 0; a < D; a++) corrupt[a] = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, k;
    logic [12:0] post;
    logic [31:0] s;
    reset = 1'b1; start = 1'b0; seed = '0;
    clr_corrupt();
    for (int a = 0; a < D; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    chk("reset.outs", 64'({wr, rd, busy, done, pass, timeout, err_cnt, first_err_addr, addr, wdata}), 64'd0);
    reset = 1'b0;

    // zero seed, ideal RAM
    run(32'h0, -1, cyc, post);
    chk("zero.lat",  64'(cyc), 64'(LAT));
    chk("zero.post", 64'(post), 64'h1000);
    chk("zero.m0",   64'(mem[0]),  INV ? 64'hFFFF_FFFF : 64'h0);
    chk("zero.m15",  64'(mem[15]), INV ? 64'h0 : 64'hFFFF_FFFF);
    check_result("zero", 32'h0);

    // two corrupted read locations
    corrupt[6] = 32'h1;
    corrupt[9] = $urandom | 32'h1;
    run(32'hA5A5_A5A5, -1, cyc, post);
    chk("corr.lat", 64'(cyc), 64'(LAT));
    check_result("corr", 32'hA5A5_A5A5);
    clr_corrupt();

    // every location corrupt: error counter saturates
    for (int a = 0; a < D; a++) corrupt[a] = 32'h8000_0000;
    s = $urandom;
    run(s, -1, cyc, post);
    check_result("sat", s);
    clr_corrupt();

    // RAM never answers the write to addr 2
    hang_en = 1'b1; wr2_cyc = 0;
    run($urandom, -1, cyc, post);
    hang_en = 1'b0;
    chk("hang.hold", 64'(wr2_cyc), 64'd15);
    chk("hang.stat", 64'({wr, rd, busy, done, pass, timeout}), 64'b000101);
    chk("hang.addr", 64'(addr), 64'd2);

    // random response delays, random seeds and corruption
    max_dly = 5;
    for (int it = 0; it < 5; it++) begin
      clr_corrupt();
      for (int j = 0; j < int'($urandom_range(2, 0)); j++)
        corrupt[$urandom_range(D-1, 0)] = $urandom | 32'h10;
      s = $urandom; viol = 0;
      run(s, -1, cyc, post);
      chk("rnd.lat", 64'(cyc >= LAT), 64'd1);
      check_result("rnd", s);
      chk("rnd.proto", 64'(viol), 64'd0);
    end
    max_dly = 0;
    clr_corrupt();

    // reset during the read phase at addr 7
    @(negedge clk);
    seed = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 0;
    while (!(rd && addr == 4'd7) && k < 2000) begin @(negedge clk); k++; end
    chk("midrst.reach", 64'(k < 2000), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst.outs", 64'({wr, rd, busy, done}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    s = $urandom;
    run(s, -1, cyc, post);
    check_result("afterrst", s);

    // start pulse while busy is ignored; start in DONE restarts and clears status
    corrupt[3] = 32'h0000_0100;
    s = $urandom;
    run(s, 20, cyc, post);
    chk("ign.lat", 64'(cyc), 64'(LAT));
    check_result("ign", s);
    clr_corrupt();
    s = $urandom; viol = 0;
    run(s, -1, cyc, post);
    chk("rerun.post", 64'(post), 64'h1000);
    chk("rerun.lat",  64'(cyc), 64'(LAT));
    check_result("rerun", s);
    chk("rerun.proto", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
